// File: rtl/dram_port_sched.sv
// dram_port_sched: shares the external DRAM read port (address out, data in) and the
// write-back port between NREQ burst requesters.
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_rd_req/addr/len         per-requester burst request (held until o_rd_gnt)
//   o_rd_gnt                  one-cycle one-hot burst accept
//   o_rd_valid/last/data      registered return beats, routed by requester id
//   o_DRAM_1_addr             registered DRAM read address
//   i_DRAM_out_data           DRAM read data, valid RD_LAT cycles after the address
//   i_wr_valid/data           per-requester write beats
//   o_wr_ready                combinational one-hot write accept
//   o_DRAM_in3_WEN/Data       registered write strobe (active-low) and data
module dram_port_sched #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [NREQ-1:0]          i_rd_req,
    input  logic [NREQ*ADDR_W-1:0]   i_rd_addr,
    input  logic [NREQ*LEN_W-1:0]    i_rd_len,
    output logic [NREQ-1:0]          o_rd_gnt,
    output logic [NREQ-1:0]          o_rd_valid,
    output logic                     o_rd_last,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic [ADDR_W-1:0]        o_DRAM_1_addr,
    input  logic [DATA_W-1:0]        i_DRAM_out_data,
    input  logic [NREQ-1:0]          i_wr_valid,
    input  logic [NREQ*DATA_W-1:0]   i_wr_data,
    output logic [NREQ-1:0]          o_wr_ready,
    output logic                     o_DRAM_in3_WEN,
    output logic [DATA_W-1:0]        o_DRAM_in3_Data
);
    localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DC_W = $clog2(RD_LAT + 2);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} rd_state_e;

    // Returns {found, index} of the first set bit at or after ptr, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [ID_W-1:0] ptr);
        logic            found;
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = ID_W'((32'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] idx);
        return ID_W'((32'(idx) + 1) % NREQ);
    endfunction

    logic [ADDR_W-1:0] req_addr [NREQ];
    logic [LEN_W-1:0]  req_len  [NREQ];
    logic [DATA_W-1:0] req_wdat [NREQ];

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_addr[i] = i_rd_addr[i*ADDR_W +: ADDR_W];
            req_len[i]  = i_rd_len[i*LEN_W +: LEN_W];
            req_wdat[i] = i_wr_data[i*DATA_W +: DATA_W];
        end
    end

    rd_state_e         state_q, state_d;
    logic [ID_W-1:0]   rr_rd_ptr_q, rr_rd_ptr_d;
    logic [ID_W-1:0]   rd_id_q, rd_id_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [DC_W-1:0]   drain_q, drain_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              issue_v, issue_last;
    logic [ID_W:0]     rd_pick;

    // Return pipeline: stage 0 lines up with the registered address, stage RD_LAT with
    // the cycle in which the DRAM presents the matching data.
    logic [RD_LAT:0]   pv_q, pl_q;
    logic [ID_W-1:0]   pid_q [RD_LAT+1];
    logic [NREQ-1:0]   rd_valid_q;
    logic              rd_last_q;
    logic [DATA_W-1:0] rd_data_q;

    logic [ID_W-1:0]   rr_wr_ptr_q;
    logic [ID_W:0]     wr_pick;
    logic              wr_fire;
    logic [ID_W-1:0]   wr_idx;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;

    always_comb begin
        state_d     = state_q;
        rr_rd_ptr_d = rr_rd_ptr_q;
        rd_id_d     = rd_id_q;
        base_d      = base_q;
        len_d       = len_q;
        beat_d      = beat_q;
        drain_d     = drain_q;
        gnt_d       = '0;
        addr_d      = addr_q;
        issue_v     = 1'b0;
        issue_last  = 1'b0;
        rd_pick     = rr_pick(i_rd_req, rr_rd_ptr_q);
        unique case (state_q)
            StIdle: begin
                if (rd_pick[ID_W]) begin
                    rd_id_d     = rd_pick[ID_W-1:0];
                    base_d      = req_addr[rd_pick[ID_W-1:0]];
                    len_d       = req_len[rd_pick[ID_W-1:0]];
                    beat_d      = '0;
                    gnt_d       = NREQ'(1) << rd_pick[ID_W-1:0];
                    rr_rd_ptr_d = ptr_after(rd_pick[ID_W-1:0]);
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                // Address wraps modulo 2^ADDR_W by truncation.
                addr_d     = base_q + ADDR_W'(beat_q);
                issue_v    = 1'b1;
                issue_last = (beat_q == len_q);
                if (issue_last) begin
                    drain_d = '0;
                    state_d = StDrain;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == DC_W'(RD_LAT)) begin
                    state_d = StIdle;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_pick    = rr_pick(i_wr_valid, rr_wr_ptr_q);
        wr_fire    = wr_pick[ID_W];
        wr_idx     = wr_pick[ID_W-1:0];
        o_wr_ready = wr_fire ? (NREQ'(1) << wr_idx) : '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= StIdle;
            rr_rd_ptr_q <= '0;
            rd_id_q     <= '0;
            base_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            drain_q     <= '0;
            gnt_q       <= '0;
            addr_q      <= '0;
            pv_q        <= '0;
            pl_q        <= '0;
            for (int unsigned i = 0; i <= RD_LAT; i++) begin
                pid_q[i] <= '0;
            end
            rd_valid_q  <= '0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
            rr_wr_ptr_q <= '0;
            wen_q       <= 1'b1;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_rd_ptr_q <= rr_rd_ptr_d;
            rd_id_q     <= rd_id_d;
            base_q      <= base_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            drain_q     <= drain_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            pv_q        <= {pv_q[RD_LAT-1:0], issue_v};
            pl_q        <= {pl_q[RD_LAT-1:0], issue_last};
            pid_q[0]    <= rd_id_q;
            for (int unsigned i = 1; i <= RD_LAT; i++) begin
                pid_q[i] <= pid_q[i-1];
            end
            rd_valid_q  <= pv_q[RD_LAT] ? (NREQ'(1) << pid_q[RD_LAT]) : '0;
            rd_last_q   <= pv_q[RD_LAT] & pl_q[RD_LAT];
            if (pv_q[RD_LAT]) begin
                rd_data_q <= i_DRAM_out_data;
            end
            wen_q <= ~wr_fire;
            if (wr_fire) begin
                wdata_q     <= req_wdat[wr_idx];
                rr_wr_ptr_q <= ptr_after(wr_idx);
            end
        end
    end

    assign o_rd_gnt        = gnt_q;
    assign o_rd_valid      = rd_valid_q;
    assign o_rd_last       = rd_last_q;
    assign o_rd_data       = rd_data_q;
    assign o_DRAM_1_addr   = addr_q;
    assign o_DRAM_in3_WEN  = wen_q;
    assign o_DRAM_in3_Data = wdata_q;

endmodule
